// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding a router input port: header, payload, XOR parity.
// Define ROUTER_PKT_TX_ERR_CHECK_EN to add a 3-cycle post-packet router error check (CHK).
module router_pkt_tx (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic [7:0] pay_data,
  output logic       pay_rd,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       reject,
  output logic [7:0] err_cnt
);

  // Handshake: the byte on data_out counts as taken by the router at every rising
  // edge where busy=0; with busy=1 everything presented to the router holds.
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
  typedef enum logic [2:0] {IDLE, HDR, PAY, PAR, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, PAY, PAR} state_t;
`endif

  state_t     state_q;
  logic [1:0] addr_q;
  logic [5:0] len_q;
  logic [5:0] cnt_q;
  logic [7:0] par_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       active_q;
  logic       done_q;
  logic       reject_q;
  logic [7:0] err_cnt_q;
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
  logic [1:0] chk_cnt_q;
  logic       err_seen_q;
`else
  logic       unused_err;
  assign unused_err = err;
`endif

  // In PAY the next byte to load is payload until cnt_q reaches the latched length.
  assign pay_rd    = (state_q == PAY) && (cnt_q != len_q) && !busy;
  assign pkt_valid = valid_q;
  assign data_out  = data_q;
  assign tx_active = active_q;
  assign done      = done_q;
  assign reject    = reject_q;
  assign err_cnt   = err_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= 2'd0;
      len_q      <= 6'd0;
      cnt_q      <= 6'd0;
      par_q      <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
      err_cnt_q  <= 8'h00;
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
      chk_cnt_q  <= 2'd0;
      err_seen_q <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (dest_addr != 2'd3 && pay_len != 6'd0) begin
              addr_q   <= dest_addr;
              len_q    <= pay_len;
              cnt_q    <= 6'd0;
              active_q <= 1'b1;
              state_q  <= HDR;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        HDR: begin
          // Nothing is on the bus yet, so the header loads regardless of busy.
          data_q  <= {len_q, addr_q};
          par_q   <= {len_q, addr_q};
          valid_q <= 1'b1;
          state_q <= PAY;
        end
        PAY: begin
          if (!busy) begin
            if (cnt_q != len_q) begin
              data_q <= pay_data;
              par_q  <= par_q ^ pay_data;
              cnt_q  <= cnt_q + 6'd1;
            end else begin
              data_q  <= par_q;
              valid_q <= 1'b0;
              state_q <= PAR;
            end
          end
        end
        PAR: begin
          if (!busy) begin
            data_q <= 8'h00;
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
            chk_cnt_q  <= 2'd0;
            err_seen_q <= 1'b0;
            state_q    <= CHK;
`else
            done_q   <= 1'b1;
            active_q <= 1'b0;
            state_q  <= IDLE;
`endif
          end
        end
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
        CHK: begin
          chk_cnt_q  <= chk_cnt_q + 2'd1;
          err_seen_q <= err_seen_q | err;
          if (chk_cnt_q == 2'd2) begin
            done_q   <= 1'b1;
            active_q <= 1'b0;
            state_q  <= IDLE;
            if ((err_seen_q || err) && err_cnt_q != 8'hFF) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx; outputs sampled 1 ns after each rising edge.
module tb_router_pkt_tx;
  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] pay_len;
  logic [7:0] pay_data;
  logic       pay_rd;
  logic       busy;
  logic       err;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       reject;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] pay [64];

  router_pkt_tx dut (
    .clk(clk), .resetn(resetn), .start(start), .dest_addr(dest_addr),
    .pay_len(pay_len), .pay_data(pay_data), .pay_rd(pay_rd), .busy(busy),
    .err(err), .pkt_valid(pkt_valid), .data_out(data_out), .tx_active(tx_active),
    .done(done), .reject(reject), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Router error count expected after k erroring packets.
  function automatic logic [7:0] cnt_after(input int k);
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
    return (k > 255) ? 8'hFF : k[7:0];
`else
    return 8'h00 + 8'(k & 0);
`endif
  endfunction

  // Sends one legal packet using pay[], holding busy for busy_len cycles while
  // byte busy_pos (0 = header) is presented; hold_start keeps start asserted.
  task automatic send_pkt(input logic [1:0] a, input logic [5:0] n, input logic [7:0] par,
                          input int busy_pos, input int busy_len, input bit hold_start,
                          input bit err_val, input logic [7:0] exp_cnt);
    logic [7:0] hdr;
    int holds;
    hdr = {n, a};
    dest_addr = a;
    pay_len = n;
    start = 1'b1;
    busy = 1'b0;
    err = err_val;
    tick();
    chk("accept_active", {7'd0, tx_active}, 8'd1);
    chk("accept_valid", {7'd0, pkt_valid}, 8'd0);
    if (hold_start) dest_addr = 2'd3;
    else start = 1'b0;
    tick();
    chk("hdr_data", data_out, hdr);
    chk("hdr_valid", {7'd0, pkt_valid}, 8'd1);
    for (int pos = 0; pos <= int'(n); pos++) begin
      holds = 0;
      forever begin
        busy = (pos == busy_pos) && (holds < busy_len);
        pay_data = (pos < int'(n)) ? pay[pos] : 8'h00;
        #1;
        chk("pay_rd", {7'd0, pay_rd}, {7'd0, (pos < int'(n)) && !busy});
        tick();
        chk("reject_quiet", {7'd0, reject}, 8'd0);
        if (!busy) break;
        holds++;
        chk("hold_data", data_out, (pos == 0) ? hdr : pay[pos-1]);
      end
      if (pos < int'(n)) begin
        chk("pay_data", data_out, pay[pos]);
        chk("pay_valid", {7'd0, pkt_valid}, 8'd1);
      end else begin
        chk("par_data", data_out, par);
        chk("par_valid", {7'd0, pkt_valid}, 8'd0);
      end
    end
    start = 1'b0;
    busy = 1'b0;
    #1;
    chk("par_pay_rd", {7'd0, pay_rd}, 8'd0);
    tick();
    chk("end_data", data_out, 8'h00);
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
    chk("chk_active", {7'd0, tx_active}, 8'd1);
    chk("chk_done", {7'd0, done}, 8'd0);
    tick();
    tick();
    tick();
`endif
    chk("done_pulse", {7'd0, done}, 8'd1);
    chk("end_active", {7'd0, tx_active}, 8'd0);
    chk("err_cnt", err_cnt, exp_cnt);
    tick();
    chk("done_once", {7'd0, done}, 8'd0);
    err = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    busy = 1'b0;
    err = 1'b0;
    dest_addr = 2'd0;
    pay_len = 6'd0;
    pay_data = 8'h00;
    #1;
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", {7'd0, pkt_valid}, 8'd0);
    chk("rst_pay_rd", {7'd0, pay_rd}, 8'd0);
    chk("rst_active", {7'd0, tx_active}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_reject", {7'd0, reject}, 8'd0);
    chk("rst_err_cnt", err_cnt, 8'h00);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // addr=1 len=2: header 0x09, parity 0x09^0xA5^0x3C = 0x90.
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    send_pkt(2'd1, 6'd2, 8'h90, -1, 0, 1'b0, 1'b0, 8'h00);
    send_pkt(2'd1, 6'd2, 8'h90, 1, 3, 1'b0, 1'b0, 8'h00);
    send_pkt(2'd1, 6'd2, 8'h90, 0, 2, 1'b1, 1'b0, 8'h00);

    // Illegal requests: reserved address, then zero length.
    dest_addr = 2'd3;
    pay_len = 6'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_addr_pulse", {7'd0, reject}, 8'd1);
    chk("rej_addr_active", {7'd0, tx_active}, 8'd0);
    chk("rej_addr_valid", {7'd0, pkt_valid}, 8'd0);
    tick();
    chk("rej_addr_once", {7'd0, reject}, 8'd0);
    chk("rej_addr_idle", {7'd0, tx_active}, 8'd0);
    dest_addr = 2'd0;
    pay_len = 6'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_len_pulse", {7'd0, reject}, 8'd1);
    chk("rej_len_active", {7'd0, tx_active}, 8'd0);
    tick();
    chk("rej_len_once", {7'd0, reject}, 8'd0);

    // Maximum length: header 0xFE, XOR(0x00..0x3E) = 0x3F, parity 0xFE^0x3F = 0xC1.
    for (int i = 0; i < 63; i++) pay[i] = 8'(i);
    send_pkt(2'd2, 6'd63, 8'hC1, 63, 2, 1'b0, 1'b0, 8'h00);

    // Reset while the second payload byte is presented.
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    dest_addr = 2'd1;
    pay_len = 6'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pay_data = 8'hA5;
    tick();
    pay_data = 8'h3C;
    tick();
    chk("mid_second_byte", data_out, 8'h3C);
    resetn = 1'b0;
    #1;
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_valid", {7'd0, pkt_valid}, 8'd0);
    chk("mid_rst_active", {7'd0, tx_active}, 8'd0);
    chk("mid_rst_pay_rd", {7'd0, pay_rd}, 8'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Fresh packet: header {1,0} = 0x04, parity 0x04^0x55 = 0x51.
    pay[0] = 8'h55;
    send_pkt(2'd0, 6'd1, 8'h51, -1, 0, 1'b0, 1'b0, 8'h00);
    send_pkt(2'd0, 6'd1, 8'h51, -1, 0, 1'b0, 1'b1, cnt_after(1));
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
    for (int k = 2; k <= 256; k++) begin
      send_pkt(2'd0, 6'd1, 8'h51, -1, 0, 1'b0, 1'b1, cnt_after(k));
    end
    send_pkt(2'd0, 6'd1, 8'h51, -1, 0, 1'b0, 1'b0, 8'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
